// File: rtl/segway_balance_seq.sv
// Balance sequencer: soft-start ramp after power grant, rider qualification from
// the load cells, and steering enable once the rider has stood balanced long enough.
module segway_balance_seq #(
  parameter logic [11:0] MIN_RIDER_WT = 12'h200,
  parameter logic [11:0] WT_HYST      = 12'h040,
  parameter int          SS_INC_CYC   = 512,
  parameter int          STEER_CYC    = 67108864
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwr_en,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic        too_fast,
  output logic        pwr_up,
  output logic [7:0]  ss_tmr,
  output logic        en_steer,
  output logic        rider_off
);

  localparam int PW = $clog2(SS_INC_CYC);
  localparam int SW = $clog2(STEER_CYC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SS_INC_CYC - 1);
  localparam logic [SW-1:0] STEER_LAST = SW'(STEER_CYC - 1);
  localparam logic [11:0]   OFF_WT     = MIN_RIDER_WT - WT_HYST;

  typedef enum logic [1:0] {ST_OFF, ST_RAMP, ST_WAIT, ST_STEER} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [SW-1:0] steer_cnt_reg, steer_cnt_next;
  logic [7:0]    ss_reg, ss_next;
  logic          pwr_up_reg, pwr_up_next;
  logic          en_steer_reg, en_steer_next;
  logic          rider_off_reg, rider_off_next;

  logic [12:0] sum;
  logic [11:0] diff;
  logic [16:0] sum_x15;
  logic        balanced, one_foot, qualified;

  assign sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign diff     = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
  assign balanced = {1'b0, diff, 2'b00} < {2'b00, sum};
  // 15*sum formed as 16*sum - sum so the whole compare stays within 17 bits
  assign sum_x15  = {sum, 4'b0000} - {4'b0000, sum};
  assign one_foot = {1'b0, diff, 4'b0000} > sum_x15;
  assign qualified = balanced & ~rider_off_reg & ~too_fast;

  always_comb begin
    rider_off_next = rider_off_reg;
    if (sum < {1'b0, OFF_WT})
      rider_off_next = 1'b1;
    else if (sum > {1'b0, MIN_RIDER_WT})
      rider_off_next = 1'b0;
  end

  always_comb begin
    state_next     = state_reg;
    presc_next     = presc_reg;
    ss_next        = ss_reg;
    steer_cnt_next = steer_cnt_reg;
    case (state_reg)
      ST_OFF: begin
        presc_next     = '0;
        ss_next        = '0;
        steer_cnt_next = '0;
        if (pwr_en) state_next = ST_RAMP;
      end
      ST_RAMP: begin
        if (presc_reg == PRESC_LAST) begin
          presc_next = '0;
          ss_next    = ss_reg + 8'd1;
          if (ss_reg == 8'd254) state_next = ST_WAIT;
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end
      ST_WAIT: begin
        if (qualified) begin
          if (steer_cnt_reg == STEER_LAST) begin
            steer_cnt_next = '0;
            state_next     = ST_STEER;
          end else begin
            steer_cnt_next = steer_cnt_reg + 1'b1;
          end
        end else begin
          steer_cnt_next = '0;
        end
      end
      ST_STEER: begin
        // losing balance alone is tolerated; only hard disqualifiers drop steering
        if (one_foot || rider_off_reg || too_fast) begin
          steer_cnt_next = '0;
          state_next     = ST_WAIT;
        end
      end
      default: state_next = ST_OFF;
    endcase
    if (!pwr_en) begin
      state_next     = ST_OFF;
      presc_next     = '0;
      ss_next        = '0;
      steer_cnt_next = '0;
    end
    pwr_up_next   = (state_next != ST_OFF);
    en_steer_next = (state_next == ST_STEER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_OFF;
      presc_reg     <= '0;
      steer_cnt_reg <= '0;
      ss_reg        <= '0;
      pwr_up_reg    <= 1'b0;
      en_steer_reg  <= 1'b0;
      rider_off_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      presc_reg     <= presc_next;
      steer_cnt_reg <= steer_cnt_next;
      ss_reg        <= ss_next;
      pwr_up_reg    <= pwr_up_next;
      en_steer_reg  <= en_steer_next;
      rider_off_reg <= rider_off_next;
    end
  end

  assign pwr_up    = pwr_up_reg;
  assign ss_tmr    = ss_reg;
  assign en_steer  = en_steer_reg;
  assign rider_off = rider_off_reg;

endmodule

// File: tb/tb_segway_balance_seq.sv
// Bench for segway_balance_seq: directed sequencing scenarios plus randomized
// load/over-speed/power stimulus, checked every clock against a behavioural model.
module tb_segway_balance_seq;

  localparam int SS = 4;
  localparam int ST = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwr_en = 1'b0;
  logic        too_fast = 1'b0;
  logic [11:0] lft_ld = '0;
  logic [11:0] rght_ld = '0;
  logic        pwr_up, en_steer, rider_off;
  logic [7:0]  ss_tmr;

  segway_balance_seq #(
    .MIN_RIDER_WT(12'h200),
    .WT_HYST(12'h040),
    .SS_INC_CYC(SS),
    .STEER_CYC(ST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pwr_en(pwr_en),
    .lft_ld(lft_ld),
    .rght_ld(rght_ld),
    .too_fast(too_fast),
    .pwr_up(pwr_up),
    .ss_tmr(ss_tmr),
    .en_steer(en_steer),
    .rider_off(rider_off)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model: powered flag, clocks elapsed since ramp start, run length of qualifying clocks
  bit m_powered, m_steer, m_ro;
  int m_ramp, m_run;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_ss();
    int s;
    s = m_ramp / SS;
    if (!m_powered) return 0;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic model_reset();
    m_powered = 1'b0;
    m_steer   = 1'b0;
    m_ro      = 1'b1;
    m_ramp    = 0;
    m_run     = 0;
  endtask

  task automatic model_step();
    int  sum, diff;
    bit  bal, one, prev_ro;
    sum  = int'(lft_ld) + int'(rght_ld);
    diff = (lft_ld >= rght_ld) ? int'(lft_ld) - int'(rght_ld) : int'(rght_ld) - int'(lft_ld);
    bal  = (4 * diff < sum);
    one  = (16 * diff > 15 * sum);
    prev_ro = m_ro;
    if (!pwr_en) begin
      m_powered = 1'b0; m_ramp = 0; m_run = 0; m_steer = 1'b0;
    end else if (!m_powered) begin
      m_powered = 1'b1; m_ramp = 0;
    end else if (m_ramp < 255 * SS) begin
      m_ramp++;
    end else if (m_steer) begin
      if (one || prev_ro || too_fast) begin
        m_steer = 1'b0; m_run = 0;
      end
    end else begin
      if (bal && !prev_ro && !too_fast) begin
        m_run++;
        if (m_run == ST) begin
          m_steer = 1'b1; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    if (sum < 'h1C0) m_ro = 1'b1;
    else if (sum > 'h200) m_ro = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    check_val("pwr_up", pwr_up, m_powered);
    check_val("ss_tmr", ss_tmr, m_ss());
    check_val("en_steer", en_steer, m_steer);
    check_val("rider_off", rider_off, m_ro);
  endtask

  task automatic cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_ld(input logic [11:0] l, input logic [11:0] r);
    lft_ld  = l;
    rght_ld = r;
  endtask

  task automatic rand_ld();
    lft_ld  = 12'($urandom_range(0, 4095));
    rght_ld = 12'($urandom_range(0, 4095));
  endtask

  initial begin
    int mode;
    int base;
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    $display("[%0t] reset released", $time);
    check_val("rst_pwr_up", pwr_up, 0);
    check_val("rst_ss_tmr", ss_tmr, 0);
    check_val("rst_en_steer", en_steer, 0);
    check_val("rst_rider_off", rider_off, 1);

    set_ld(12'h0F8, 12'h0F8); cycle(); check_val("hyst_hold_set", rider_off, 1);
    set_ld(12'h100, 12'h101); cycle(); check_val("hyst_clear", rider_off, 0);
    set_ld(12'h0F8, 12'h0F8); cycle(); check_val("hyst_hold_clr", rider_off, 0);
    set_ld(12'h0D8, 12'h0D8); cycle(); check_val("hyst_set", rider_off, 1);
    set_ld(12'h100, 12'h101); cycle(); check_val("hyst_clear2", rider_off, 0);
    $display("[%0t] hysteresis sequence done", $time);

    pwr_en = 1'b1;
    cycle();
    check_val("pwrup_rise", pwr_up, 1);
    check_val("ramp_start_ss", ss_tmr, 0);
    for (int k = 0; k < 4; k++) begin rand_ld(); cycle(); end
    check_val("ss_first_step", ss_tmr, 1);
    for (int k = 0; k < 600 && m_ss() != 100; k++) begin rand_ld(); cycle(); end
    check_val("ss_at_100", ss_tmr, 100);
    pwr_en = 1'b0;
    cycle();
    check_val("drop_ramp_pwr_up", pwr_up, 0);
    check_val("drop_ramp_ss", ss_tmr, 0);
    check_val("drop_ramp_en", en_steer, 0);
    $display("[%0t] power dropped mid-ramp", $time);

    pwr_en = 1'b1;
    cycle();
    check_val("restart_ss", ss_tmr, 0);
    check_val("restart_pwr_up", pwr_up, 1);
    for (int k = 0; k < 1015; k++) begin rand_ld(); cycle(); end
    set_ld(12'h600, 12'h000);
    cycles(4);
    check_val("ss_254", ss_tmr, 254);
    cycle();
    check_val("ss_255", ss_tmr, 255);
    check_val("ramp_en_steer", en_steer, 0);
    cycles(3);
    $display("[%0t] ramp complete", $time);

    set_ld(12'h300, 12'h300); cycles(10);
    set_ld(12'h600, 12'h000); cycle();
    set_ld(12'h300, 12'h300); cycles(15);
    check_val("steer_early", en_steer, 0);
    cycle();
    check_val("steer_rise", en_steer, 1);
    $display("[%0t] steering acquired after glitch", $time);

    set_ld(12'h400, 12'h100); cycles(3);
    check_val("steer_hold_unbal", en_steer, 1);
    set_ld(12'h500, 12'h010); cycle();
    check_val("one_foot_exit", en_steer, 0);
    set_ld(12'h300, 12'h300); cycles(16);
    check_val("steer_reacq", en_steer, 1);
    too_fast = 1'b1; cycle();
    check_val("too_fast_exit", en_steer, 0);
    too_fast = 1'b0; cycles(16);
    check_val("steer_reacq2", en_steer, 1);
    $display("[%0t] steering exits exercised", $time);

    pwr_en = 1'b0; cycle();
    check_val("drop_steer_pwr_up", pwr_up, 0);
    check_val("drop_steer_ss", ss_tmr, 0);
    check_val("drop_steer_en", en_steer, 0);
    pwr_en = 1'b1; cycle();
    check_val("restart2_ss", ss_tmr, 0);
    cycles(255 * SS + ST);
    check_val("steer_after_restart", en_steer, 1);
    $display("[%0t] power dropped in steer and reacquired", $time);

    #2 rst = 1'b1;
    #1;
    check_val("async_pwr_up", pwr_up, 0);
    check_val("async_ss_tmr", ss_tmr, 0);
    check_val("async_en_steer", en_steer, 0);
    check_val("async_rider_off", rider_off, 1);
    model_reset();
    cycle();
    #2 rst = 1'b0;
    $display("[%0t] async reset mid-steer", $time);

    mode = 0;
    for (int n = 0; n < 8000; n++) begin
      if ($urandom_range(0, 23) == 0) mode = int'($urandom_range(0, 3));
      case (mode)
        0: begin
          base = int'($urandom_range(12'h100, 12'h700));
          set_ld(12'(base + int'($urandom_range(0, 12'h20))), 12'(base));
        end
        1: rand_ld();
        2: set_ld(12'($urandom_range(12'h300, 12'hFFF)), 12'($urandom_range(0, 12'h10)));
        default: set_ld(12'($urandom_range(0, 12'h110)), 12'($urandom_range(0, 12'h110)));
      endcase
      too_fast = ($urandom_range(0, 63) == 0);
      pwr_en   = ($urandom_range(0, 2999) != 0);
      cycle();
    end
    $display("[%0t] random phase done", $time);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
